// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//   - state_t     : FSM state encoding (IDLE / RUN / DONE)
//   - WIDTH_MIN   : smallest operand width the datapath supports
//   - cnt_width() : bit counter width derived from the operand width
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;

    // Counter must index bits 0..w-1; guard keeps the result at least 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   Combinational 1-bit full-subtractor cell: d = x - y - bin.
//   Ports:
//     x    : minuend bit
//     y    : subtrahend bit
//     bin  : borrow-in
//     d    : difference bit
//     bout : borrow-out (x < y + bin)
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic xy_diff;

    always_comb begin
        xy_diff = x ^ y;
        d       = xy_diff ^ bin;
        // Borrow when y exceeds x, or when x == y and a borrow arrives.
        bout    = (~x & y) | (~xy_diff & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per
//   clock, LSB first, through a single full-subtractor cell with a
//   registered borrow. start/busy/done handshake; diff and bout hold until
//   the next operation completes.
//   Parameters:
//     WIDTH : operand/result width (>= 2)
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : request, sampled only in IDLE
//     a, b   : minuend / subtrahend, captured on accepted start
//     bin    : borrow-in, captured on accepted start
//     busy   : high while in RUN
//     done   : one-cycle pulse when diff/bout become valid
//     diff   : registered difference
//     bout   : registered borrow-out (a < b + bin, unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic             cell_d;
    logic             cell_bo;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        // Result register with this cycle's bit already in the MSB; on the
        // last bit this is the complete difference.
        sr_next  = {cell_d, sr[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, serial shift and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            brw <= 1'b0;
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    brw <= cell_bo;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers update only on the RUN->DONE transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (state == RUN && last_bit) begin
            diff <= sr_next;
            bout <= cell_bo;
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor, the inverse of the datapath's full-adder arithmetic.
- Computes diff = a - b - bin one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
- Used where area matters more than latency; the parallel adder stays for throughput paths.
- Uses a start/busy/done handshake. Result registers hold their value until the next operation completes.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse when diff/bout become valid
diff  output  WIDTH  registered result (a - b - bin) mod 2^WIDTH
bout  output  1  registered borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow register and bit counter cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load sa<=a, sb<=b, brw<=bin, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN (busy=1):
  - Each cycle the cell computes d = sa[0]^sb[0]^brw and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw).
  - Shift sa and sb right by one. Shift d into the MSB of the result shift register. brw<=bo; cnt<=cnt+1.
  - On the cycle where cnt==WIDTH-1: copy the completed shift register, including this cycle's d, to diff; bout<=bo; state<=DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then state<=IDLE unconditionally.
  - start asserted in DONE is ignored; it must be re-asserted in IDLE.
- Latency: start accepted at edge N; busy high for edges N+1..N+WIDTH; done high during cycle N+WIDTH+1. Next start can be accepted at edge N+WIDTH+2.
- start asserted while busy is ignored; a, b and bin may change freely after acceptance without affecting the result.
- diff and bout change only on the RUN->DONE transition and hold their value through IDLE and subsequent RUN.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is reported only via bout; there is no separate overflow flag.
- Counter width is clog2(WIDTH); the terminal compare is against WIDTH-1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the localparam for counter width derivation.
- Sub-module full_subtractor: combinational 1-bit cell (x, y, bin -> d, bout), instantiated once.
- Shift, count and FSM logic live in serial_subtractor.

Test Plan:
- Reset: rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, diff=8'h00, bout=0; no operation starts until rst_n=1 and start is seen in IDLE.
- Basic subtraction: a=8'd100, b=8'd37, bin=0, start pulse -> busy high exactly 8 cycles; done 1 cycle; diff=8'd63, bout=0.
- Borrow/wrap: a=8'd5, b=8'd9, bin=1 -> diff=8'hFB, bout=1. Also a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
- Busy protection: start with a=8'hF0, b=8'h0F; at RUN cycle 3 assert start with a=0, b=0 and change a/b -> diff=8'hE1, bout=0; no second operation begins. start held through DONE is not accepted until the IDLE cycle.
- Reset mid-operation: start a=8'd200, b=8'd1; drop rst_n at RUN cycle 4 -> immediate busy=0, diff=0; no done pulse. After release, a new start completes normally.
- Exhaustive sweep with WIDTH=4: all a, b and bin combinations, back-to-back starts issued in each IDLE cycle -> diff == (a-b-bin) mod 16, bout == (a < b+bin); each done follows its start by exactly WIDTH+1 cycles.
